// File: rtl/data_sram_if.sv
// Load/store request and response signals between the execute/memory stages
// and the data memory responder.
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Fixed-latency, in-order data memory responder.
//
// Because every request takes exactly LATENCY cycles, the in-flight queue is
// kept as an age-indexed pipeline: slot k holds the entry accepted k+1 cycles
// ago. The head of the queue is always the oldest valid slot, and it matures
// in slot LATENCY-1, which makes data_ok and rdata plain register outputs.
// The number of valid slots is the queue occupancy and is what throttles
// acceptance against OUTSTANDING.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input logic      clk,
  input logic      reset,
  data_sram_if.slave bus
);
  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] OUT_LIM = 4'(OUTSTANDING);

  logic [31:0]           mem [DEPTH];
  logic [LATENCY-1:0]    valid;
  logic [31:0]           data_pipe [LATENCY];
  logic [3:0]            count;
  logic                  accept;
  logic                  retire;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_bits;

  // Byte offset and bits above the array size are don't-care; upper bits alias.
  assign idx              = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

  assign retire      = valid[LATENCY-1];
  assign bus.data_ok = retire;
  assign bus.addr_ok = (count < OUT_LIM) || retire;
  assign bus.rdata   = data_pipe[LATENCY-1];
  assign accept      = bus.req && bus.addr_ok && !reset;

  // Queue occupancy: number of requests still waiting for their response.
  always_comb begin
    count = '0;
    for (int k = 0; k < LATENCY; k++) begin
      count = count + 4'(valid[k]);
    end
  end

  // Age pipeline; stores carry zero so rdata is zero for them and when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        data_pipe[k] <= '0;
      end
    end else begin
      valid[0]     <= accept;
      data_pipe[0] <= (accept && !bus.wr) ? mem[idx] : '0;
      for (int k = 1; k < LATENCY; k++) begin
        valid[k]     <= valid[k-1];
        data_pipe[k] <= data_pipe[k-1];
      end
    end
  end

  // Byte-masked array write; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: three instances cover
// (LATENCY,OUTSTANDING) = (2,2), (3,1) and (3,2).
module tb_data_sram_responder;
  typedef struct {
    int          d;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_d = 1'b0;
  logic        wr_d = 1'b0;
  logic [31:0] addr_d = '0;
  logic [3:0]  wstrb_d = '0;
  logic [31:0] wdata_d = '0;
  int          sel = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          dok_cnt [3] = '{0, 0, 0};
  exp_t        sb [$];
  logic [31:0] mdl [3][1024];
  logic [2:0]  aok;
  logic [2:0]  dok;
  logic [31:0] rd [3];

  data_sram_if bus0 ();
  data_sram_if bus1 ();
  data_sram_if bus2 ();

  assign bus0.req = req_d && (sel == 0);
  assign bus1.req = req_d && (sel == 1);
  assign bus2.req = req_d && (sel == 2);
  assign bus0.wr = wr_d;      assign bus1.wr = wr_d;      assign bus2.wr = wr_d;
  assign bus0.addr = addr_d;  assign bus1.addr = addr_d;  assign bus2.addr = addr_d;
  assign bus0.wstrb = wstrb_d; assign bus1.wstrb = wstrb_d; assign bus2.wstrb = wstrb_d;
  assign bus0.wdata = wdata_d; assign bus1.wdata = wdata_d; assign bus2.wdata = wdata_d;

  assign aok = {bus2.addr_ok, bus1.addr_ok, bus0.addr_ok};
  assign dok = {bus2.data_ok, bus1.data_ok, bus0.data_ok};
  assign rd[0] = bus0.rdata;
  assign rd[1] = bus1.rdata;
  assign rd[2] = bus2.rdata;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .OUTSTANDING(2))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3), .OUTSTANDING(1))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3), .OUTSTANDING(2))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp acceptances and responses.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: each data_ok pops the scoreboard head and checks data and timing.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dok[i]) begin
        exp_t e;
        dok_cnt[i]++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_dut", 32'(i), 32'(e.d));
          chk("resp_rdata", rd[i], e.data);
          chk("resp_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("rdata_idle", rd[i], 32'd0);
      end
    end
  end

  // Present one request and hold it until accepted; req stays high on return.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] dt, output int waited);
    exp_t e;
    int   idx;
    @(negedge clk);
    sel = d; req_d = 1'b1; wr_d = w; addr_d = a; wstrb_d = s; wdata_d = dt;
    waited = 0;
    #1;
    while (!(aok[d] && !reset) && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("accept_timeout", 32'(waited < 40), 32'd1);
    idx = int'(a[11:2]);
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[d][idx][8*b +: 8] = dt[8*b +: 8];
      end
      e.data = '0;
    end else begin
      e.data = mdl[d][idx];
    end
    e.d = d;
    e.due = cyc + lat_of(d);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_d = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w;
    int base;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_addr_ok", 32'(aok[i]), 32'd1);
      chk("rst_data_ok", 32'(dok[i]), 32'd0);
      chk("rst_rdata", rd[i], 32'd0);
    end

    // Store then load the same word back to back.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, w);
    drain();
    chk("model_basic", mdl[0][4], 32'hDEADBEEF);

    // Byte merge, then an all-zero strobe store that must not change the word.
    issue(0, 1'b1, 32'h20, 4'hF, 32'hDEADBEEF, w);
    issue(0, 1'b1, 32'h20, 4'b0010, 32'h0000AA00, w);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, w);
    issue(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, w);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, w);
    drain();
    chk("model_merge", mdl[0][8], 32'hDEADAAEF);

    // Back-to-back: 8 stores then 8 loads with req held high.
    base = dok_cnt[0];
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b1, 32'(i * 4), 4'hF, 32'h1000_0000 + 32'(i * 32'h0101_1111), w);
      chk("b2b_wait", 32'(w), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b0, 32'(i * 4), 4'h0, 32'h0, w);
      chk("b2b_wait", 32'(w), 32'd0);
    end
    drain();
    chk("b2b_pulses", 32'(dok_cnt[0] - base), 32'd16);

    // Full stall on LATENCY=3, OUTSTANDING=1: one acceptance every 3 cycles.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) issue(1, 1'b1, 32'(32'h80 + i * 4), 4'hF, 32'hA5A5_0000 + 32'(i), w);
      else       issue(1, 1'b0, 32'(32'h80 + (i - 4) * 4), 4'h0, 32'h0, w);
      if (i == 0) begin
        chk("stall_wait0", 32'(w), 32'd0);
      end else begin
        chk("stall_wait", 32'(w), 32'd2);
        chk("stall_dok", 32'(dok[1]), 32'd1);
      end
    end
    drain();

    // Reset while two loads are in flight; a store presented during reset is dropped.
    issue(2, 1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, w);
    issue(2, 1'b1, 32'h44, 4'hF, 32'h0BAD_CAFE, w);
    drain();
    issue(2, 1'b0, 32'h40, 4'h0, 32'h0, w);
    issue(2, 1'b0, 32'h44, 4'h0, 32'h0, w);
    chk("rst_mid_inflight", 32'(sb.size()), 32'd2);
    base = dok_cnt[2];
    @(negedge clk);
    reset = 1'b1;
    sel = 2; req_d = 1'b1; wr_d = 1'b1; addr_d = 32'h40; wstrb_d = 4'hF; wdata_d = 32'h1111_2222;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    req_d = 1'b0;
    #1;
    chk("post_rst_addr_ok", 32'(aok[2]), 32'd1);
    chk("post_rst_data_ok", 32'(dok[2]), 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_dropped", 32'(dok_cnt[2] - base), 32'd0);
    issue(2, 1'b0, 32'h40, 4'h0, 32'h0, w);
    drain();
    chk("model_persist", mdl[2][16], 32'hCAFE_F00D);

    // Aliasing and ignored low bits.
    issue(0, 1'b1, 32'h13, 4'hF, 32'h12345678, w);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, w);
    issue(0, 1'b0, 32'h10 + (32'd4 << 10), 4'h0, 32'h0, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
